// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: combinational hold/flush/bubble steering, zero added latency; mem stall > redirect > load-use.
// Optional performance counters are built only when HAZARD_PERF_CNT_EN is defined; otherwise the ports read 0.
module hazard_ctrl #(
    parameter int LOAD_USE_CYCLES = 1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [4:0]  i_id_rs1_addr,
    input  logic [4:0]  i_id_rs2_addr,
    input  logic        i_id_rs1_used,
    input  logic        i_id_rs2_used,
    input  logic        i_id_valid,
    input  logic [4:0]  i_ex_rd_addr,
    input  logic        i_ex_mem_read,
    input  logic        i_ex_valid,
    input  logic        i_ex_redirect,
    input  logic        i_mem_req,
    input  logic        i_mem_ready,
    output logic        o_pc_hold,
    output logic        o_if_id_hold,
    output logic        o_id_ex_hold,
    output logic        o_ex_mem_hold,
    output logic        o_id_ex_bubble,
    output logic        o_if_id_flush,
    output logic        o_id_ex_flush,
    output logic [1:0]  o_state,
    output logic [31:0] o_stall_cycles,
    output logic [31:0] o_flush_events
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        MEM_WAIT = 2'd2,
        ILLEGAL  = 2'd3
    } state_t;

    // Extra bubble cycles spent in LU_STALL after the first stall cycle in RUN.
    localparam logic [1:0] LU_EXTRA = 2'(LOAD_USE_CYCLES - 1);

    state_t     state, state_nxt;
    logic [1:0] cnt, cnt_nxt;
    logic       pend, pend_nxt;
    logic       mem_wait, load_use, redirect;

    assign mem_wait = i_mem_req & ~i_mem_ready;
    assign load_use = i_ex_valid & i_ex_mem_read & (i_ex_rd_addr != 5'd0) & i_id_valid &
                      ((i_id_rs1_used & (i_id_rs1_addr == i_ex_rd_addr)) |
                       (i_id_rs2_used & (i_id_rs2_addr == i_ex_rd_addr)));
    assign redirect = i_ex_redirect | pend;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= RUN;
            cnt   <= 2'd0;
            pend  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            pend  <= pend_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        pend_nxt  = pend;
        case (state)
            RUN, MEM_WAIT: begin
                if (mem_wait) begin
                    state_nxt = MEM_WAIT;
                    pend_nxt  = pend | i_ex_redirect;
                end else if (redirect) begin
                    state_nxt = RUN;
                    pend_nxt  = 1'b0;
                    cnt_nxt   = 2'd0;
                end else if (load_use && (LU_EXTRA != 2'd0)) begin
                    state_nxt = LU_STALL;
                    cnt_nxt   = LU_EXTRA;
                end else begin
                    state_nxt = RUN;
                end
            end
            LU_STALL: begin
                // A memory stall freezes the bubble count; the redirect is remembered.
                if (mem_wait) begin
                    pend_nxt = pend | i_ex_redirect;
                end else if (redirect) begin
                    state_nxt = RUN;
                    pend_nxt  = 1'b0;
                    cnt_nxt   = 2'd0;
                end else begin
                    cnt_nxt   = cnt - 2'd1;
                    state_nxt = (cnt <= 2'd1) ? RUN : LU_STALL;
                end
            end
            default: begin
                state_nxt = RUN;
                cnt_nxt   = 2'd0;
                pend_nxt  = 1'b0;
            end
        endcase
    end

    always_comb begin
        o_pc_hold      = 1'b0;
        o_if_id_hold   = 1'b0;
        o_id_ex_hold   = 1'b0;
        o_ex_mem_hold  = 1'b0;
        o_id_ex_bubble = 1'b0;
        o_if_id_flush  = 1'b0;
        o_id_ex_flush  = 1'b0;
        o_state        = 2'd0;
        if (i_rst_n && (state != ILLEGAL)) begin
            o_state = state;
            if (mem_wait) begin
                o_pc_hold     = 1'b1;
                o_if_id_hold  = 1'b1;
                o_id_ex_hold  = 1'b1;
                o_ex_mem_hold = 1'b1;
            end else if (redirect) begin
                o_if_id_flush = 1'b1;
                o_id_ex_flush = 1'b1;
            end else if ((state == LU_STALL) || load_use) begin
                o_pc_hold      = 1'b1;
                o_if_id_hold   = 1'b1;
                o_id_ex_bubble = 1'b1;
            end
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_q, flush_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            stall_q <= 32'd0;
            flush_q <= 32'd0;
        end else begin
            if (o_pc_hold | o_if_id_hold | o_id_ex_hold | o_ex_mem_hold | o_id_ex_bubble)
                stall_q <= stall_q + 32'd1;
            if (o_id_ex_flush)
                flush_q <= flush_q + 32'd1;
        end
    end

    assign o_stall_cycles = stall_q;
    assign o_flush_events = flush_q;
`else
    assign o_stall_cycles = 32'd0;
    assign o_flush_events = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: two instances (1 and 2 load-use bubbles) share stimulus and are checked every cycle.
module tb_hazard_ctrl;

`ifdef HAZARD_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    localparam logic [6:0] O_NONE = 7'b0000000;
    localparam logic [6:0] O_LU   = 7'b1100100;
    localparam logic [6:0] O_MW   = 7'b1111000;
    localparam logic [6:0] O_FL   = 7'b0000011;

    typedef struct packed {
        logic       rst_n;
        logic       ld;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic       u1;
        logic [4:0] rs2;
        logic       u2;
        logic       redir;
        logic       req;
        logic       rdy;
    } stim_t;

    typedef struct packed {
        stim_t      s;
        logic [8:0] e1;
        logic [8:0] e2;
    } row_t;

    logic        i_clk, i_rst_n;
    logic [4:0]  i_id_rs1_addr, i_id_rs2_addr, i_ex_rd_addr;
    logic        i_id_rs1_used, i_id_rs2_used, i_id_valid;
    logic        i_ex_mem_read, i_ex_valid, i_ex_redirect, i_mem_req, i_mem_ready;

    logic        pc1, ifh1, idh1, exh1, bub1, iff1, idf1;
    logic        pc2, ifh2, idh2, exh2, bub2, iff2, idf2;
    logic [1:0]  st1, st2;
    logic [31:0] stall1, flush1, stall2, flush2;
    logic [8:0]  obs1, obs2;

    logic [17:0] sb[$];
    int checks = 0;
    int failures = 0;

    assign obs1 = {st1, pc1, ifh1, idh1, exh1, bub1, iff1, idf1};
    assign obs2 = {st2, pc2, ifh2, idh2, exh2, bub2, iff2, idf2};

    hazard_ctrl #(.LOAD_USE_CYCLES(1)) u_lu1 (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_id_rs1_addr(i_id_rs1_addr), .i_id_rs2_addr(i_id_rs2_addr),
        .i_id_rs1_used(i_id_rs1_used), .i_id_rs2_used(i_id_rs2_used), .i_id_valid(i_id_valid),
        .i_ex_rd_addr(i_ex_rd_addr), .i_ex_mem_read(i_ex_mem_read), .i_ex_valid(i_ex_valid),
        .i_ex_redirect(i_ex_redirect), .i_mem_req(i_mem_req), .i_mem_ready(i_mem_ready),
        .o_pc_hold(pc1), .o_if_id_hold(ifh1), .o_id_ex_hold(idh1), .o_ex_mem_hold(exh1),
        .o_id_ex_bubble(bub1), .o_if_id_flush(iff1), .o_id_ex_flush(idf1), .o_state(st1),
        .o_stall_cycles(stall1), .o_flush_events(flush1)
    );

    hazard_ctrl #(.LOAD_USE_CYCLES(2)) u_lu2 (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_id_rs1_addr(i_id_rs1_addr), .i_id_rs2_addr(i_id_rs2_addr),
        .i_id_rs1_used(i_id_rs1_used), .i_id_rs2_used(i_id_rs2_used), .i_id_valid(i_id_valid),
        .i_ex_rd_addr(i_ex_rd_addr), .i_ex_mem_read(i_ex_mem_read), .i_ex_valid(i_ex_valid),
        .i_ex_redirect(i_ex_redirect), .i_mem_req(i_mem_req), .i_mem_ready(i_mem_ready),
        .o_pc_hold(pc2), .o_if_id_hold(ifh2), .o_id_ex_hold(idh2), .o_ex_mem_hold(exh2),
        .o_id_ex_bubble(bub2), .o_if_id_flush(iff2), .o_id_ex_flush(idf2), .o_state(st2),
        .o_stall_cycles(stall2), .o_flush_events(flush2)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    function automatic stim_t mk(input logic rn, input logic ld, input logic [4:0] rd,
                                 input logic [4:0] rs1, input logic u1,
                                 input logic [4:0] rs2, input logic u2,
                                 input logic redir, input logic req, input logic rdy);
        stim_t s;
        s.rst_n = rn; s.ld = ld; s.rd = rd; s.rs1 = rs1; s.u1 = u1;
        s.rs2 = rs2; s.u2 = u2; s.redir = redir; s.req = req; s.rdy = rdy;
        return s;
    endfunction

    function automatic logic [8:0] ev(input logic [1:0] st, input logic [6:0] o);
        return {st, o};
    endfunction

    function automatic row_t r(input stim_t s, input logic [8:0] e1, input logic [8:0] e2);
        row_t x;
        x.s = s; x.e1 = e1; x.e2 = e2;
        return x;
    endfunction

    function automatic stim_t idle();
        return mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    // Applies one cycle of stimulus, queues its expected outputs and waits for the sample point.
    task automatic drive(input row_t x);
        i_rst_n       = x.s.rst_n;
        i_ex_valid    = x.s.ld;
        i_ex_mem_read = x.s.ld;
        i_ex_rd_addr  = x.s.rd;
        i_id_valid    = 1'b1;
        i_id_rs1_addr = x.s.rs1;
        i_id_rs1_used = x.s.u1;
        i_id_rs2_addr = x.s.rs2;
        i_id_rs2_used = x.s.u2;
        i_ex_redirect = x.s.redir;
        i_mem_req     = x.s.req;
        i_mem_ready   = x.s.rdy;
        sb.push_back({x.e1, x.e2});
        @(negedge i_clk);
    endtask

    task automatic test_reset();
        row_t q[$];
        logic [17:0] exp;
        q.push_back(r(mk(0, 1, 5, 5, 1, 0, 0, 1, 1, 0), ev(0, O_NONE), ev(0, O_NONE)));
        q.push_back(r(mk(0, 1, 5, 5, 1, 0, 0, 1, 1, 0), ev(0, O_NONE), ev(0, O_NONE)));
        q.push_back(r(idle(), ev(0, O_NONE), ev(0, O_NONE)));
        for (int i = 0; i < q.size(); i++) begin
            drive(q[i]);
            exp = sb.pop_front();
            checks += 2;
            if (obs1 !== exp[17:9]) begin failures++; $display("FAIL reset[%0d] lu1 got=%b exp=%b", i, obs1, exp[17:9]); end
            if (obs2 !== exp[8:0])  begin failures++; $display("FAIL reset[%0d] lu2 got=%b exp=%b", i, obs2, exp[8:0]); end
            @(posedge i_clk); #1;
        end
        checks += 2;
        if (stall1 !== 32'd0 || flush1 !== 32'd0) begin failures++; $display("FAIL reset_cnt lu1 got=%0d/%0d exp=0/0", stall1, flush1); end
        if (stall2 !== 32'd0 || flush2 !== 32'd0) begin failures++; $display("FAIL reset_cnt lu2 got=%0d/%0d exp=0/0", stall2, flush2); end
    endtask

    task automatic test_load_use();
        row_t q[$];
        logic [17:0] exp;
        q.push_back(r(mk(1, 1, 5, 5, 1, 0, 0, 0, 0, 0), ev(0, O_LU), ev(0, O_LU)));
        q.push_back(r(mk(1, 0, 5, 5, 1, 0, 0, 0, 0, 0), ev(0, O_NONE), ev(1, O_LU)));
        q.push_back(r(idle(), ev(0, O_NONE), ev(0, O_NONE)));
        q.push_back(r(mk(1, 1, 5, 5, 0, 9, 1, 0, 0, 0), ev(0, O_NONE), ev(0, O_NONE)));
        for (int i = 0; i < q.size(); i++) begin
            drive(q[i]);
            exp = sb.pop_front();
            checks += 2;
            if (obs1 !== exp[17:9]) begin failures++; $display("FAIL load_use[%0d] lu1 got=%b exp=%b", i, obs1, exp[17:9]); end
            if (obs2 !== exp[8:0])  begin failures++; $display("FAIL load_use[%0d] lu2 got=%b exp=%b", i, obs2, exp[8:0]); end
            @(posedge i_clk); #1;
        end
    endtask

    task automatic test_rd_zero_rs2();
        row_t q[$];
        logic [17:0] exp;
        q.push_back(r(mk(1, 1, 0, 3, 0, 0, 1, 0, 0, 0), ev(0, O_NONE), ev(0, O_NONE)));
        q.push_back(r(mk(1, 1, 7, 3, 0, 7, 1, 0, 0, 0), ev(0, O_LU), ev(0, O_LU)));
        q.push_back(r(mk(1, 0, 7, 3, 0, 7, 1, 0, 0, 0), ev(0, O_NONE), ev(1, O_LU)));
        q.push_back(r(idle(), ev(0, O_NONE), ev(0, O_NONE)));
        for (int i = 0; i < q.size(); i++) begin
            drive(q[i]);
            exp = sb.pop_front();
            checks += 2;
            if (obs1 !== exp[17:9]) begin failures++; $display("FAIL rd_zero_rs2[%0d] lu1 got=%b exp=%b", i, obs1, exp[17:9]); end
            if (obs2 !== exp[8:0])  begin failures++; $display("FAIL rd_zero_rs2[%0d] lu2 got=%b exp=%b", i, obs2, exp[8:0]); end
            @(posedge i_clk); #1;
        end
    endtask

    task automatic test_mem_wait();
        row_t q[$];
        logic [17:0] exp;
        q.push_back(r(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0), ev(0, O_MW), ev(0, O_MW)));
        q.push_back(r(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0), ev(2, O_MW), ev(2, O_MW)));
        q.push_back(r(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0), ev(2, O_MW), ev(2, O_MW)));
        q.push_back(r(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 1), ev(2, O_NONE), ev(2, O_NONE)));
        q.push_back(r(idle(), ev(0, O_NONE), ev(0, O_NONE)));
        for (int i = 0; i < q.size(); i++) begin
            drive(q[i]);
            exp = sb.pop_front();
            checks += 2;
            if (obs1 !== exp[17:9]) begin failures++; $display("FAIL mem_wait[%0d] lu1 got=%b exp=%b", i, obs1, exp[17:9]); end
            if (obs2 !== exp[8:0])  begin failures++; $display("FAIL mem_wait[%0d] lu2 got=%b exp=%b", i, obs2, exp[8:0]); end
            @(posedge i_clk); #1;
        end
    endtask

    task automatic test_mem_redirect();
        row_t q[$];
        logic [17:0] exp;
        logic [31:0] exp_stall, exp_flush;
        q.push_back(r(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), ev(0, O_NONE), ev(0, O_NONE)));
        q.push_back(r(mk(1, 0, 0, 0, 0, 0, 0, 1, 1, 0), ev(0, O_MW), ev(0, O_MW)));
        q.push_back(r(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0), ev(2, O_MW), ev(2, O_MW)));
        q.push_back(r(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0), ev(2, O_MW), ev(2, O_MW)));
        q.push_back(r(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 1), ev(2, O_FL), ev(2, O_FL)));
        q.push_back(r(idle(), ev(0, O_NONE), ev(0, O_NONE)));
        for (int i = 0; i < q.size(); i++) begin
            drive(q[i]);
            exp = sb.pop_front();
            checks += 2;
            if (obs1 !== exp[17:9]) begin failures++; $display("FAIL mem_redirect[%0d] lu1 got=%b exp=%b", i, obs1, exp[17:9]); end
            if (obs2 !== exp[8:0])  begin failures++; $display("FAIL mem_redirect[%0d] lu2 got=%b exp=%b", i, obs2, exp[8:0]); end
            @(posedge i_clk); #1;
        end
        exp_stall = PERF ? 32'd3 : 32'd0;
        exp_flush = PERF ? 32'd1 : 32'd0;
        checks += 4;
        if (stall1 !== exp_stall) begin failures++; $display("FAIL stall_cnt lu1 got=%0d exp=%0d", stall1, exp_stall); end
        if (flush1 !== exp_flush) begin failures++; $display("FAIL flush_cnt lu1 got=%0d exp=%0d", flush1, exp_flush); end
        if (stall2 !== exp_stall) begin failures++; $display("FAIL stall_cnt lu2 got=%0d exp=%0d", stall2, exp_stall); end
        if (flush2 !== exp_flush) begin failures++; $display("FAIL flush_cnt lu2 got=%0d exp=%0d", flush2, exp_flush); end
    endtask

    task automatic test_redirect_lu_stall();
        row_t q[$];
        logic [17:0] exp;
        q.push_back(r(mk(1, 1, 7, 0, 0, 7, 1, 0, 0, 0), ev(0, O_LU), ev(0, O_LU)));
        q.push_back(r(mk(1, 0, 7, 0, 0, 7, 1, 1, 0, 0), ev(0, O_FL), ev(1, O_FL)));
        q.push_back(r(idle(), ev(0, O_NONE), ev(0, O_NONE)));
        for (int i = 0; i < q.size(); i++) begin
            drive(q[i]);
            exp = sb.pop_front();
            checks += 2;
            if (obs1 !== exp[17:9]) begin failures++; $display("FAIL redirect_lu[%0d] lu1 got=%b exp=%b", i, obs1, exp[17:9]); end
            if (obs2 !== exp[8:0])  begin failures++; $display("FAIL redirect_lu[%0d] lu2 got=%b exp=%b", i, obs2, exp[8:0]); end
            @(posedge i_clk); #1;
        end
    endtask

    task automatic test_priority();
        row_t q[$];
        logic [17:0] exp;
        q.push_back(r(mk(1, 1, 5, 5, 1, 0, 0, 1, 1, 0), ev(0, O_MW), ev(0, O_MW)));
        q.push_back(r(mk(1, 1, 5, 5, 1, 0, 0, 0, 1, 1), ev(2, O_FL), ev(2, O_FL)));
        q.push_back(r(idle(), ev(0, O_NONE), ev(0, O_NONE)));
        q.push_back(r(mk(1, 1, 5, 5, 1, 0, 0, 0, 0, 0), ev(0, O_LU), ev(0, O_LU)));
        q.push_back(r(mk(1, 0, 5, 5, 1, 0, 0, 0, 1, 0), ev(0, O_MW), ev(1, O_MW)));
        q.push_back(r(mk(1, 0, 5, 5, 1, 0, 0, 0, 1, 1), ev(2, O_NONE), ev(1, O_LU)));
        q.push_back(r(idle(), ev(0, O_NONE), ev(0, O_NONE)));
        for (int i = 0; i < q.size(); i++) begin
            drive(q[i]);
            exp = sb.pop_front();
            checks += 2;
            if (obs1 !== exp[17:9]) begin failures++; $display("FAIL priority[%0d] lu1 got=%b exp=%b", i, obs1, exp[17:9]); end
            if (obs2 !== exp[8:0])  begin failures++; $display("FAIL priority[%0d] lu2 got=%b exp=%b", i, obs2, exp[8:0]); end
            @(posedge i_clk); #1;
        end
    endtask

    task automatic test_reset_mid_wait();
        row_t q[$];
        logic [17:0] exp;
        q.push_back(r(mk(1, 0, 0, 0, 0, 0, 0, 1, 1, 0), ev(0, O_MW), ev(0, O_MW)));
        q.push_back(r(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0), ev(2, O_MW), ev(2, O_MW)));
        q.push_back(r(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0), ev(0, O_NONE), ev(0, O_NONE)));
        q.push_back(r(idle(), ev(0, O_NONE), ev(0, O_NONE)));
        q.push_back(r(idle(), ev(0, O_NONE), ev(0, O_NONE)));
        for (int i = 0; i < q.size(); i++) begin
            drive(q[i]);
            exp = sb.pop_front();
            checks += 2;
            if (obs1 !== exp[17:9]) begin failures++; $display("FAIL reset_mid[%0d] lu1 got=%b exp=%b", i, obs1, exp[17:9]); end
            if (obs2 !== exp[8:0])  begin failures++; $display("FAIL reset_mid[%0d] lu2 got=%b exp=%b", i, obs2, exp[8:0]); end
            @(posedge i_clk); #1;
        end
        checks += 2;
        if (stall1 !== 32'd0 || flush1 !== 32'd0) begin failures++; $display("FAIL reset_mid_cnt lu1 got=%0d/%0d exp=0/0", stall1, flush1); end
        if (stall2 !== 32'd0 || flush2 !== 32'd0) begin failures++; $display("FAIL reset_mid_cnt lu2 got=%0d/%0d exp=0/0", stall2, flush2); end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_rd_zero_rs2();
        test_mem_wait();
        test_mem_redirect();
        test_redirect_lu_stall();
        test_priority();
        test_reset_mid_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
